generador_inmediato_seg: RTL and testbench

Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage. It accepts raw instruction words over a valid/ready handshake and decodes the format from the opcode itself, with an optional external `tipo` override. It returns the sign-extended immediate, format code and an illegal-opcode flag one cycle later. A skid buffer lets it sustain one instruction per cycle under downstream back-pressure, and a saturating counter records illegal opcodes.

---
 rtl/generador_inmediato_seg_if.sv | 27 ++
 rtl/generador_inmediato_seg.sv | 156 +++++++++++++++
 tb/tb_generador_inmediato_seg.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generador_inmediato_seg_if.sv
// Instruction-in / immediate-out handshake bundle for generador_inmediato_seg.
// The master side offers words and consumes results; the slave side is the generator.
interface generador_inmediato_seg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic [31:0]      inst;
  logic [2:0]       tipo;
  logic             inst_valido;
  logic             inst_listo;
  logic [XLEN-1:0]  inmediato;
  logic [2:0]       formato;
  logic             ilegal;
  logic             sal_valido;
  logic             sal_listo;
  logic [CNT_W-1:0] cuenta_ilegal;

  modport master (
    output inst, tipo, inst_valido, sal_listo,
    input  inst_listo, inmediato, formato, ilegal, sal_valido, cuenta_ilegal
  );

  modport slave (
    input  inst, tipo, inst_valido, sal_listo,
    output inst_listo, inmediato, formato, ilegal, sal_valido, cuenta_ilegal
  );
endinterface

// File: rtl/generador_inmediato_seg.sv
// RV32I/RV64I immediate generator: decoded result one cycle after acceptance, 1/cycle throughput.
// inst_listo is registered; a skid entry holds the word already in flight when sal_listo drops.
module generador_inmediato_seg #(
  parameter int XLEN         = 32,
  parameter int TIPO_EXTERNO = 0,
  parameter int CNT_W        = 16
) (
  input logic                      clk,
  input logic                      rst,
  generador_inmediato_seg_if.slave bus
);
  localparam logic [2:0] F_I   = 3'd0;
  localparam logic [2:0] F_S   = 3'd1;
  localparam logic [2:0] F_B   = 3'd2;
  localparam logic [2:0] F_U   = 3'd3;
  localparam logic [2:0] F_J   = 3'd4;
  localparam logic [2:0] F_R   = 3'd5;
  localparam logic [2:0] F_ILL = 3'd7;

  typedef struct packed {
    logic            ileg;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } ent_t;

  typedef enum logic [1:0] {VACIO, UNO, LLENO} occ_e;

  occ_e             state_q, state_d;
  ent_t             main_q, main_d;
  ent_t             skid_q, skid_d;
  logic             inst_listo_q, inst_listo_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [2:0]  dec_fmt;
  logic [31:0] imm32;
  ent_t        dec;
  logic        sal_valido;
  logic        in_xfer, out_xfer;
  logic        load_main, load_skid, move_skid;

  assign op = bus.inst[6:0];
  assign f3 = bus.inst[14:12];

  always_comb begin
    dec_fmt = F_ILL;
    if (TIPO_EXTERNO != 0) begin
      if (bus.tipo <= F_J) dec_fmt = bus.tipo;
    end else begin
      case (op)
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = F_I;
        7'b0100011:                                     dec_fmt = F_S;
        7'b1100011:                                     dec_fmt = F_B;
        7'b0110111, 7'b0010111:                         dec_fmt = F_U;
        7'b1101111:                                     dec_fmt = F_J;
        7'b0110011:                                     dec_fmt = F_R;
        7'b0011011:                                     dec_fmt = (XLEN == 64) ? F_I : F_ILL;
        7'b0111011:                                     dec_fmt = (XLEN == 64) ? F_R : F_ILL;
        default:                                        dec_fmt = F_ILL;
      endcase
    end
  end

  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      F_I:     imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
      F_S:     imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
      F_B:     imm32 = {{20{bus.inst[31]}}, bus.inst[7], bus.inst[30:25], bus.inst[11:8], 1'b0};
      F_U:     imm32 = {bus.inst[31:12], 12'b0};
      F_J:     imm32 = {{12{bus.inst[31]}}, bus.inst[19:12], bus.inst[20], bus.inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Shift immediates carry a zero-extended shamt; bit 30 is the SRAI marker, not data.
    if (dec_fmt == F_I && (f3 == 3'b001 || f3 == 3'b101)) begin
      if (op == 7'b0010011 && XLEN == 64)
        imm32 = {26'b0, bus.inst[25:20]};
      else if (op == 7'b0010011 || op == 7'b0011011)
        imm32 = {27'b0, bus.inst[24:20]};
    end
  end

  always_comb begin
    dec      = '0;
    dec.fmt  = dec_fmt;
    dec.ileg = (dec_fmt == F_ILL);
    dec.imm  = XLEN'(signed'(imm32));
  end

  assign sal_valido = (state_q != VACIO);
  assign in_xfer    = bus.inst_valido & inst_listo_q;
  assign out_xfer   = sal_valido & bus.sal_listo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= VACIO;
      main_q       <= '0;
      skid_q       <= '0;
      inst_listo_q <= 1'b0;
      cuenta_q     <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      inst_listo_q <= inst_listo_d;
      cuenta_q     <= cuenta_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VACIO: if (in_xfer) state_d = UNO;
      UNO: begin
        if (in_xfer && !out_xfer)      state_d = LLENO;
        else if (!in_xfer && out_xfer) state_d = VACIO;
      end
      LLENO:   if (out_xfer) state_d = UNO;
      default: state_d = VACIO;
    endcase
  end

  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      VACIO: load_main = in_xfer;
      UNO: begin
        load_main = in_xfer && out_xfer;
        load_skid = in_xfer && !out_xfer;
      end
      LLENO:   move_skid = out_xfer;
      default: ;
    endcase
  end

  always_comb begin
    main_d = main_q;
    if (load_main)      main_d = dec;
    else if (move_skid) main_d = skid_q;
    skid_d       = load_skid ? dec : skid_q;
    inst_listo_d = (state_d != LLENO);
    cuenta_d     = cuenta_q;
    if (in_xfer && dec.ileg && cuenta_q != {CNT_W{1'b1}})
      cuenta_d = cuenta_q + CNT_W'(1);
  end

  assign bus.inst_listo    = inst_listo_q;
  assign bus.sal_valido    = sal_valido;
  assign bus.inmediato     = main_q.imm;
  assign bus.formato       = main_q.fmt;
  assign bus.ilegal        = main_q.ileg;
  assign bus.cuenta_ilegal = cuenta_q;
endmodule

// File: tb/tb_generador_inmediato_seg.sv
// Bench for generador_inmediato_seg: RV32 auto-decode, RV64 auto-decode (2-bit counter), RV32 external tipo.
module tb_generador_inmediato_seg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  generador_inmediato_seg_if #(.XLEN(32), .CNT_W(16)) b0 ();
  generador_inmediato_seg_if #(.XLEN(64), .CNT_W(2))  b1 ();
  generador_inmediato_seg_if #(.XLEN(32), .CNT_W(16)) b2 ();

  generador_inmediato_seg #(.XLEN(32), .TIPO_EXTERNO(0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  generador_inmediato_seg #(.XLEN(64), .TIPO_EXTERNO(0), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(b1));
  generador_inmediato_seg #(.XLEN(32), .TIPO_EXTERNO(1), .CNT_W(16)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  logic [31:0] i_inst [3];
  logic [2:0]  i_tipo [3];
  logic        i_vld  [3];
  logic        i_sl   [3];
  logic [63:0] o_imm  [3];
  logic [2:0]  o_fmt  [3];
  logic        o_ileg [3];
  logic        o_vld  [3];
  logic        o_listo[3];
  logic [15:0] o_cnt  [3];

  assign b0.inst = i_inst[0]; assign b0.tipo = i_tipo[0]; assign b0.inst_valido = i_vld[0]; assign b0.sal_listo = i_sl[0];
  assign b1.inst = i_inst[1]; assign b1.tipo = i_tipo[1]; assign b1.inst_valido = i_vld[1]; assign b1.sal_listo = i_sl[1];
  assign b2.inst = i_inst[2]; assign b2.tipo = i_tipo[2]; assign b2.inst_valido = i_vld[2]; assign b2.sal_listo = i_sl[2];

  assign o_imm[0] = 64'(b0.inmediato); assign o_fmt[0] = b0.formato; assign o_ileg[0] = b0.ilegal;
  assign o_vld[0] = b0.sal_valido;     assign o_listo[0] = b0.inst_listo; assign o_cnt[0] = b0.cuenta_ilegal;
  assign o_imm[1] = b1.inmediato;      assign o_fmt[1] = b1.formato; assign o_ileg[1] = b1.ilegal;
  assign o_vld[1] = b1.sal_valido;     assign o_listo[1] = b1.inst_listo; assign o_cnt[1] = 16'(b1.cuenta_ilegal);
  assign o_imm[2] = 64'(b2.inmediato); assign o_fmt[2] = b2.formato; assign o_ileg[2] = b2.ilegal;
  assign o_vld[2] = b2.sal_valido;     assign o_listo[2] = b2.inst_listo; assign o_cnt[2] = b2.cuenta_ilegal;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ileg;
  } exp_t;

  typedef struct {
    int          k;
    logic [31:0] w;
    logic [2:0]  t;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ileg;
  } vec_t;

  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] LUI  = 32'h123450B7;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: format by opcode table (or tipo), immediate assembled as signed integer weights.
  function automatic exp_t model(input int k, input logic [31:0] w, input logic [2:0] t);
    exp_t       e;
    longint     v;
    bit         rv64;
    logic [6:0] op;
    logic [2:0] f3;
    rv64  = (k == 1);
    op    = w[6:0];
    f3    = w[14:12];
    e.fmt = 3'd7;
    if (k == 2) begin
      if (t <= 3'd4) e.fmt = t;
    end else begin
      if (op inside {7'h13, 7'h03, 7'h67, 7'h73} || (rv64 && op == 7'h1B)) e.fmt = 3'd0;
      else if (op == 7'h23)                        e.fmt = 3'd1;
      else if (op == 7'h63)                        e.fmt = 3'd2;
      else if (op inside {7'h37, 7'h17})           e.fmt = 3'd3;
      else if (op == 7'h6F)                        e.fmt = 3'd4;
      else if (op == 7'h33 || (rv64 && op == 7'h3B)) e.fmt = 3'd5;
    end
    v = 0;
    case (e.fmt)
      3'd0: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; end
      3'd1: begin v = longint'(w[31:25]) * 32 + longint'(w[11:7]); if (w[31]) v -= 4096; end
      3'd2: begin
        v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v -= 4096;
      end
      3'd3: begin v = longint'(w[31:12]) * 4096; if (w[31]) v -= longint'(1) << 32; end
      3'd4: begin
        v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v -= longint'(1) << 20;
      end
      default: v = 0;
    endcase
    if (e.fmt == 3'd0 && (f3 == 3'd1 || f3 == 3'd5) && (op == 7'h13 || op == 7'h1B))
      v = (rv64 && op == 7'h13) ? longint'(w[25:20]) : longint'(w[24:20]);
    e.imm  = rv64 ? 64'(v) : {32'b0, v[31:0]};
    e.ileg = (e.fmt == 3'd7);
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 1) != 0) w[14:12] = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101;
    return w;
  endfunction

  task automatic idle_all();
    for (int j = 0; j < 3; j++) begin
      i_vld[j] = 1'b0;
      i_sl[j]  = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic send(input int k, input logic [31:0] w, input logic [2:0] t);
    @(negedge clk);
    i_inst[k] = w;
    i_tipo[k] = t;
    i_vld[k]  = 1'b1;
    i_sl[k]   = 1'b1;
    @(posedge clk);
    #1 i_vld[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_random(input int k, input int n);
    exp_t q[$];
    exp_t e;
    int   nill;
    int   maxc;
    nill = 0;
    maxc = (k == 1) ? 3 : 65535;
    for (int c = 0; c < n + 12; c++) begin
      @(posedge clk);
      #1;
      if (c < n) begin
        i_vld[k]  = ($urandom_range(0, 3) != 0);
        i_inst[k] = rnd_inst();
        i_tipo[k] = 3'($urandom);
        i_sl[k]   = ($urandom_range(0, 2) != 0);
      end else begin
        i_vld[k] = 1'b0;
        i_sl[k]  = 1'b1;
      end
      @(negedge clk);
      chk("rnd_sal_valido", 64'(o_vld[k]), 64'(q.size() != 0));
      chk("rnd_inst_listo", 64'(o_listo[k]), 64'(q.size() < 2));
      if (o_vld[k] && q.size() != 0) begin
        chk($sformatf("rnd%0d_imm", k), o_imm[k], q[0].imm);
        chk($sformatf("rnd%0d_fmt", k), 64'(o_fmt[k]), 64'(q[0].fmt));
        chk($sformatf("rnd%0d_ilegal", k), 64'(o_ileg[k]), 64'(q[0].ileg));
        if (i_sl[k]) void'(q.pop_front());
      end
      if (i_vld[k] && o_listo[k]) begin
        e = model(k, i_inst[k], i_tipo[k]);
        q.push_back(e);
        if (e.ileg) nill++;
      end
    end
    chk("rnd_drained", 64'(q.size()), 64'd0);
    chk($sformatf("rnd%0d_cuenta", k), 64'(o_cnt[k]), 64'((nill > maxc) ? maxc : nill));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[15];
    vt[0]  = '{0, ADDI,         3'd0, 64'hFFFFFFFF,         3'd0, 1'b0};
    vt[1]  = '{0, BEQ,          3'd0, 64'hFFFFFFFC,         3'd2, 1'b0};
    vt[2]  = '{0, LUI,          3'd0, 64'h12345000,         3'd3, 1'b0};
    vt[3]  = '{0, 32'h4030D093, 3'd0, 64'h3,                3'd0, 1'b0};
    vt[4]  = '{0, 32'h01F09093, 3'd0, 64'h1F,               3'd0, 1'b0};
    vt[5]  = '{0, 32'h0000007F, 3'd0, 64'h0,                3'd7, 1'b1};
    vt[6]  = '{0, 32'h002081B3, 3'd0, 64'h0,                3'd5, 1'b0};
    vt[7]  = '{0, 32'h0010809B, 3'd0, 64'h0,                3'd7, 1'b1};
    vt[8]  = '{1, 32'h800000B7, 3'd0, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
    vt[9]  = '{1, 32'h03F09093, 3'd0, 64'h3F,               3'd0, 1'b0};
    vt[10] = '{1, 32'h0010809B, 3'd0, 64'h1,                3'd0, 1'b0};
    vt[11] = '{1, 32'hFE112E23, 3'd0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    vt[12] = '{2, 32'hFF5FF080, 3'd4, 64'hFFFFFFF4,         3'd4, 1'b0};
    vt[13] = '{2, ADDI,         3'd0, 64'hFFFFFFFF,         3'd0, 1'b0};
    vt[14] = '{2, 32'h00000013, 3'd5, 64'h0,                3'd7, 1'b1};

    for (int j = 0; j < 3; j++) begin
      i_inst[j] = '0;
      i_tipo[j] = '0;
    end
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sal_valido", 64'(o_vld[0]), 64'd0);
    chk("rst_inmediato", o_imm[0], 64'd0);
    chk("rst_formato", 64'(o_fmt[0]), 64'd0);
    chk("rst_ilegal", 64'(o_ileg[0]), 64'd0);
    chk("rst_cuenta", 64'(o_cnt[0]), 64'd0);
    chk("rst_inst_listo", 64'(o_listo[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inst_listo", 64'(o_listo[0]), 64'd1);

    for (int i = 0; i < 15; i++) begin
      send(vt[i].k, vt[i].w, vt[i].t);
      chk($sformatf("vec%0d_valido", i), 64'(o_vld[vt[i].k]), 64'd1);
      chk($sformatf("vec%0d_imm", i), o_imm[vt[i].k], vt[i].imm);
      chk($sformatf("vec%0d_fmt", i), 64'(o_fmt[vt[i].k]), 64'(vt[i].fmt));
      chk($sformatf("vec%0d_ilegal", i), 64'(o_ileg[vt[i].k]), 64'(vt[i].ileg));
    end
    chk("cuenta_dut0", 64'(o_cnt[0]), 64'd2);
    chk("cuenta_dut2", 64'(o_cnt[2]), 64'd1);

    // 2-bit counter must stop at 3.
    for (int i = 0; i < 5; i++) begin
      send(1, 32'h0000007F, 3'd0);
      chk($sformatf("sat_cuenta%0d", i), 64'(o_cnt[1]), 64'((i + 1 > 3) ? 3 : i + 1));
    end

    do_reset();
    @(negedge clk);
    i_sl[0] = 1'b0; i_inst[0] = ADDI; i_vld[0] = 1'b1;
    @(posedge clk); #1 i_inst[0] = LUI;
    @(posedge clk); #1 i_inst[0] = BEQ;
    @(negedge clk);
    chk("bp_listo_full", 64'(o_listo[0]), 64'd0);
    chk("bp_valido", 64'(o_vld[0]), 64'd1);
    chk("bp_imm_first", o_imm[0], 64'hFFFFFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_imm", o_imm[0], 64'hFFFFFFFF);
    chk("bp_hold_listo", 64'(o_listo[0]), 64'd0);
    i_sl[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_out2_imm", o_imm[0], 64'h12345000);
    chk("bp_out2_listo", 64'(o_listo[0]), 64'd1);
    @(posedge clk); #1 i_vld[0] = 1'b0;
    @(negedge clk);
    chk("bp_out3_imm", o_imm[0], 64'hFFFFFFFC);
    chk("bp_out3_fmt", 64'(o_fmt[0]), 64'd2);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", 64'(o_vld[0]), 64'd0);

    // Fill both entries (second word illegal), then reset.
    i_sl[0] = 1'b0; i_inst[0] = ADDI; i_vld[0] = 1'b1;
    @(posedge clk); #1 i_inst[0] = 32'h0000007F;
    @(posedge clk); #1 i_vld[0] = 1'b0;
    @(negedge clk);
    chk("full_listo", 64'(o_listo[0]), 64'd0);
    chk("full_cuenta", 64'(o_cnt[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valido", 64'(o_vld[0]), 64'd0);
    chk("midrst_listo", 64'(o_listo[0]), 64'd0);
    chk("midrst_cuenta", 64'(o_cnt[0]), 64'd0);
    chk("midrst_imm", o_imm[0], 64'd0);
    rst = 1'b0;
    i_sl[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_after_listo", 64'(o_listo[0]), 64'd1);
    chk("midrst_after_valido", 64'(o_vld[0]), 64'd0);

    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_random(k, 600);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
